abh_sequencer: RTL and testbench
================================

# abh_sequencer

Sequencer for the 65C02 address-bus-high (ABH) multiplexer. Accepts one addressing-mode request at a time and steps the mux's one-hot `CNTL` through the per-cycle source sequence for that mode: PC high, data latch, or fixed page. It also handles memory wait states and the indexed/indirect page-cross fix-up cycle. It sits between the instruction decoder and the ABH mux.

## Interface
Parameters:
- `MODE_W`, 3, width of the addressing-mode code.

Ports:
- `CLK`  in  1  single system clock; all state changes on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `START`  in  1  request a new sequence; sampled only when `ACCEPT` is 1.
- `MODE`  in  `MODE_W`  addressing mode, sampled with `START`.
- `READY`  in  1  memory ready; 0 stalls the current step.
- `CARRY`  in  1  carry out of the address-low adder; valid in effective-address cycles.
- `CNTL`  out  3  one-hot ABH mux select. Bit 0 selects `IN0` (PC high), bit 1 selects `IN1` (data latch), bit 2 selects `IN2` (fixed page). 000 means idle.
- `PAGE1`  out  1  fixed-page value select: 0 is page 0x00, 1 is page 0x01 (stack). Meaningful only when `CNTL[2]` is 1.
- `INC_ABH`  out  1  increment ABH for page-cross fix-up.
- `BUSY`  out  1  a sequence is in progress.
- `DONE`  out  1  last step completes this cycle (its step is active and `READY` is 1).
- `ACCEPT`  out  1  `START` is taken this cycle; equals `~BUSY | DONE`.

## Operation
Modes and per-cycle `CNTL` sequences:
- 0 IMP: `001`.
- 1 ZP: `001`, then `100` with `PAGE1`=0.
- 2 ABS: `001`, `001`, `010`.
- 3 ABSX: `001`, `001`, `010`, then `010` with `INC_ABH`=1 only if `CARRY`=1 during the third step.
- 4 STK: `001`, then `100` with `PAGE1`=1.
- 5 IND: `001`, `001`, `010`, `010`. If `CARRY`=1 in the third step, `INC_ABH`=1 in the fourth step.
- 6 and 7 are reserved and execute as IMP.

FSM states:
- IDLE: `CNTL`=000, `BUSY`=0.
- STEP: a step counter (0..3) indexes the sequence for the latched mode.
- FIX: page-cross step.

Transitions:
- IDLE → STEP(0) on `START`.
- STEP(n) → STEP(n+1) on `READY`.
- Last STEP → FIX on `READY` & `CARRY`, in ABSX only.
- Last step with `READY` → STEP(0) of the new mode if `START`, else IDLE.

Rules:
- `READY`=0 freezes state, step counter, `CNTL`, `PAGE1` and `INC_ABH`.
- `CARRY` is sampled only on a `READY`=1 edge of the qualifying step.
- `CNTL` is always exactly one-hot or 000.

## Timing
- Reset values:
  - `CNTL`=000
  - `PAGE1`=0
  - `INC_ABH`=0
  - `BUSY`=0
  - `DONE`=0
  - state IDLE, step counter 0
  - latched mode 0
- `RST` overrides everything, including mid-sequence and stalled cycles. The output is IDLE on the cycle after the reset edge.
- All outputs are registered except `DONE` and `ACCEPT`, which are combinational from state and `READY`.
- Latency: `START` high at edge k gives the first step's `CNTL` valid after edge k. There is no idle bubble for back-to-back requests accepted on a `DONE` cycle.
- Sequence length with all `READY`=1:
  - IMP: 1 cycle
  - ZP and STK: 2 cycles
  - ABS: 3 cycles
  - ABSX: 3 or 4 cycles
  - IND: 4 cycles
- `START` while `BUSY` and not `DONE` is ignored. No queuing.

## Configuration
- `ABH_SEQ_PAGEFIX_EN` defined:
  - FIX step exists.
  - `CARRY` is honoured as described above.
- Not defined:
  - `CARRY` is ignored.
  - `INC_ABH` is tied to 0.
  - ABSX is always 3 cycles.
  - IND's fourth step is `010` without increment, so the pointer high byte wraps within its page (NMOS behaviour).

## Structure
- Package `abh_seq_pkg` holds:
  - mode encodings: `MODE_IMP`..`MODE_IND`
  - one-hot select constants: `SEL_PCH`=001, `SEL_DL`=010, `SEL_PAGE`=100
  - FSM state enum
  - per-mode sequence length constant
- One sub-module, `abh_seq_step_rom`: a combinational (mode, step) → {`CNTL`, `PAGE1`, last-step flag} decode. The FSM, counter and `CARRY` handling stay in the top module.

## Test plan
- Reset mid-IND (step 2, `READY`=0): assert `RST` for 1 cycle → next cycle `CNTL`=000, `BUSY`=0, `INC_ABH`=0. A following `START` with MODE=2 yields `001`,`001`,`010`.
- ABS back-to-back: MODE=2, then `START` MODE=4 on the `DONE` cycle → `CNTL` 001,001,010,001,100 with `PAGE1`=1 on the last cycle. No 000 gap.
- ABSX with `CARRY`=1 in step 2 (macro defined) → 001,001,010,010. `INC_ABH`=1 only on the 4th cycle; `DONE` on the 4th. With the macro undefined → 3 cycles, `INC_ABH` never 1.
- ZP with `READY` low for 3 cycles during step 1 → `CNTL`=100, `PAGE1`=0 held 4 cycles. `DONE` only in the cycle `READY` returns to 1.
- Reserved MODE=7 → single `001` cycle, then IDLE.
- Protocol: `START` pulsed while busy and not `DONE` → ignored; the sequence count is unchanged. `CNTL` one-hot or 000 every cycle (assertion).

Source files
------------

// File: rtl/abh_seq_pkg.sv
// rtl/abh_seq_pkg.sv - shared encodings for the ABH mux sequencer
package abh_seq_pkg;

  // Addressing-mode codes; 6 and 7 are reserved and run as IMP
  localparam int MODE_IMP  = 0;
  localparam int MODE_ZP   = 1;
  localparam int MODE_ABS  = 2;
  localparam int MODE_ABSX = 3;
  localparam int MODE_STK  = 4;
  localparam int MODE_IND  = 5;

  // One-hot ABH mux selects
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_PCH  = 3'b001;
  localparam logic [2:0] SEL_DL   = 3'b010;
  localparam logic [2:0] SEL_PAGE = 3'b100;

  // Longest per-mode sequence in steps (IND), excluding the fix-up step
  localparam int SEQ_LEN_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_FIX  = 2'd2
  } abh_state_t;

  // Number of steps for a mode with every READY high and no page cross
  function automatic int seq_len(input int mode);
    case (mode)
      MODE_ZP, MODE_STK:   return 2;
      MODE_ABS, MODE_ABSX: return 3;
      MODE_IND:            return SEQ_LEN_MAX;
      default:             return 1;
    endcase
  endfunction

endpackage

// File: rtl/abh_seq_step_rom.sv
// rtl/abh_seq_step_rom.sv - (mode, step) to mux select, page select and last-step decode
module abh_seq_step_rom
  import abh_seq_pkg::*;
#(
  parameter int MODE_W = 3
) (
  input  logic [MODE_W-1:0] mode,
  input  logic [1:0]        step,
  output logic [2:0]        cntl,
  output logic              page1,
  output logic              last
);

  int mode_i;
  assign mode_i = int'(mode);

  // Pure table lookup; steps past the end of a mode are never addressed
  always_comb begin
    cntl  = SEL_PCH;
    page1 = 1'b0;
    last  = (int'(step) == seq_len(mode_i) - 1);
    case (mode_i)
      MODE_ZP: begin
        cntl = (step == 2'd0) ? SEL_PCH : SEL_PAGE;
      end
      MODE_STK: begin
        cntl  = (step == 2'd0) ? SEL_PCH : SEL_PAGE;
        page1 = (step != 2'd0);
      end
      MODE_ABS, MODE_ABSX, MODE_IND: begin
        cntl = (step < 2'd2) ? SEL_PCH : SEL_DL;
      end
      default: begin
        cntl = SEL_PCH;
      end
    endcase
  end

endmodule

// File: rtl/abh_sequencer.sv
// rtl/abh_sequencer.sv - ABH mux sequencer top; page-cross fix-up enabled by ABH_SEQ_PAGEFIX_EN
module abh_sequencer
  import abh_seq_pkg::*;
#(
  parameter int MODE_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [MODE_W-1:0] MODE,
  input  logic              READY,
  input  logic              CARRY,
  output logic [2:0]        CNTL,
  output logic              PAGE1,
  output logic              INC_ABH,
  output logic              BUSY,
  output logic              DONE,
  output logic              ACCEPT
);

`ifdef ABH_SEQ_PAGEFIX_EN
  localparam bit PAGEFIX_EN = 1'b1;
`else
  localparam bit PAGEFIX_EN = 1'b0;
`endif

  abh_state_t        state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [2:0]        cntl_q, cntl_d;
  logic              page1_q, page1_d;
  logic              inc_abh_q, inc_abh_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;

  logic              fix_hit;
  logic              done_c;
  logic              take;
  logic [MODE_W-1:0] rom_mode;
  logic [1:0]        rom_step;
  logic [2:0]        rom_cntl;
  logic              rom_page1;
  logic              rom_last;

  // The ROM always decodes the step that will be active after the next edge
  abh_seq_step_rom #(.MODE_W(MODE_W)) u_rom (
    .mode  (rom_mode),
    .step  (rom_step),
    .cntl  (rom_cntl),
    .page1 (rom_page1),
    .last  (rom_last)
  );

  // Completion and hand-off decode; an ABSX page cross defers completion to FIX
  always_comb begin
    fix_hit  = PAGEFIX_EN && (int'(mode_q) == MODE_ABSX) && CARRY;
    done_c   = READY && (((state_q == ST_STEP) && last_q && !fix_hit) || (state_q == ST_FIX));
    take     = START && ((state_q == ST_IDLE) || done_c);
    rom_mode = take ? MODE : mode_q;
    rom_step = take ? 2'd0 : step_q + 2'd1;
  end

  // Next-state: new request wins on a done cycle, otherwise advance only when READY
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    mode_d    = mode_q;
    cntl_d    = cntl_q;
    page1_d   = page1_q;
    inc_abh_d = inc_abh_q;
    last_d    = last_q;
    if (take) begin
      state_d   = ST_STEP;
      step_d    = 2'd0;
      mode_d    = MODE;
      cntl_d    = rom_cntl;
      page1_d   = rom_page1;
      inc_abh_d = 1'b0;
      last_d    = rom_last;
    end else if (READY) begin
      case (state_q)
        ST_STEP: begin
          if (!last_q) begin
            step_d    = step_q + 2'd1;
            cntl_d    = rom_cntl;
            page1_d   = rom_page1;
            last_d    = rom_last;
            inc_abh_d = PAGEFIX_EN && (int'(mode_q) == MODE_IND) && (step_q == 2'd2) && CARRY;
          end else if (fix_hit) begin
            state_d   = ST_FIX;
            cntl_d    = SEL_DL;
            page1_d   = 1'b0;
            inc_abh_d = 1'b1;
            last_d    = 1'b0;
          end else begin
            state_d   = ST_IDLE;
            step_d    = 2'd0;
            cntl_d    = SEL_NONE;
            page1_d   = 1'b0;
            inc_abh_d = 1'b0;
            last_d    = 1'b0;
          end
        end
        ST_FIX: begin
          state_d   = ST_IDLE;
          step_d    = 2'd0;
          cntl_d    = SEL_NONE;
          page1_d   = 1'b0;
          inc_abh_d = 1'b0;
          last_d    = 1'b0;
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // FSM and registered outputs; reset wins over stalls and new requests
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      step_q    <= 2'd0;
      mode_q    <= '0;
      cntl_q    <= SEL_NONE;
      page1_q   <= 1'b0;
      inc_abh_q <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      cntl_q    <= cntl_d;
      page1_q   <= page1_d;
      inc_abh_q <= inc_abh_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
    end
  end

  assign CNTL    = cntl_q;
  assign PAGE1   = page1_q;
  assign INC_ABH = inc_abh_q;
  assign BUSY    = busy_q;
  assign DONE    = done_c;
  assign ACCEPT  = (state_q == ST_IDLE) || done_c;

endmodule

// File: tb/tb_abh_sequencer.sv
// tb/tb_abh_sequencer.sv - self-checking bench for abh_sequencer
module tb_abh_sequencer;

`ifdef ABH_SEQ_PAGEFIX_EN
  localparam bit FIXEN = 1'b1;
`else
  localparam bit FIXEN = 1'b0;
`endif

  logic       clk;
  logic       RST, START, READY, CARRY;
  logic [2:0] MODE;
  logic [2:0] CNTL;
  logic       PAGE1, INC_ABH, BUSY, DONE, ACCEPT;

  int errors = 0;
  int checks = 0;

  abh_sequencer #(.MODE_W(3)) dut (
    .CLK(clk), .RST(RST), .START(START), .MODE(MODE), .READY(READY), .CARRY(CARRY),
    .CNTL(CNTL), .PAGE1(PAGE1), .INC_ABH(INC_ABH), .BUSY(BUSY), .DONE(DONE), .ACCEPT(ACCEPT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of remaining steps, head is the active one
  typedef struct {
    logic [2:0] cntl;
    logic       page1;
    logic       inc;
    logic       cpt;
  } mstep_t;
  mstep_t q[$];

  logic [2:0] s_cntl;
  logic       s_page1, s_inc, s_busy, s_done;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add_step(input logic [2:0] c, input logic p, input logic cp);
    mstep_t s;
    s.cntl = c; s.page1 = p; s.inc = 1'b0; s.cpt = cp;
    q.push_back(s);
  endtask

  task automatic push_mode(input int m);
    case (m)
      1: begin add_step(3'b001, 0, 0); add_step(3'b100, 0, 0); end
      2: begin add_step(3'b001, 0, 0); add_step(3'b001, 0, 0); add_step(3'b010, 0, 0); end
      3: begin add_step(3'b001, 0, 0); add_step(3'b001, 0, 0); add_step(3'b010, 0, 1); end
      4: begin add_step(3'b001, 0, 0); add_step(3'b100, 1, 0); end
      5: begin add_step(3'b001, 0, 0); add_step(3'b001, 0, 0); add_step(3'b010, 0, 1);
               add_step(3'b010, 0, 0); end
      default: add_step(3'b001, 0, 0);
    endcase
  endtask

  // One clock cycle: drive, sample, compare with the model, advance the model
  task automatic cyc(input logic rst, input logic st, input int md, input logic rdy, input logic cy);
    logic       busy, e_done, e_acc;
    logic [2:0] e_cntl;
    logic       e_page, e_inc;
    mstep_t     fx;
    @(negedge clk);
    RST = rst; START = st; MODE = md[2:0]; READY = rdy; CARRY = cy;
    #1;
    s_cntl = CNTL; s_page1 = PAGE1; s_inc = INC_ABH; s_busy = BUSY; s_done = DONE;
    busy = (q.size() > 0);
    if (rdy && busy && q[0].cpt && cy && FIXEN) begin
      if (q.size() == 1) begin
        fx.cntl = 3'b010; fx.page1 = 1'b0; fx.inc = 1'b1; fx.cpt = 1'b0;
        q.push_back(fx);
      end else begin
        q[1].inc = 1'b1;
      end
    end
    e_cntl = busy ? q[0].cntl : 3'b000;
    e_page = busy ? q[0].page1 : 1'b0;
    e_inc  = busy ? q[0].inc : 1'b0;
    e_done = busy && rdy && (q.size() == 1);
    e_acc  = !busy || e_done;
    chk("onehot", {7'd0, $onehot0(CNTL)}, 8'd1);
    chk("cntl", {5'd0, CNTL}, {5'd0, e_cntl});
    if (e_cntl[2]) chk("page1", {7'd0, PAGE1}, {7'd0, e_page});
    chk("inc_abh", {7'd0, INC_ABH}, {7'd0, e_inc});
    chk("busy", {7'd0, BUSY}, {7'd0, busy});
    chk("done", {7'd0, DONE}, {7'd0, e_done});
    chk("accept", {7'd0, ACCEPT}, {7'd0, e_acc});
    if (rst) begin
      q.delete();
    end else begin
      if (rdy && busy) q.delete(0);
      if (e_acc && st) push_mode(md);
    end
  endtask

  typedef struct {
    logic       rst, st;
    int         md;
    logic       rdy;
    logic [2:0] cntl;
    logic       page1, busy, done;
  } vec_t;
  vec_t tbl[$];

  task automatic v(input logic rst, input logic st, input int md, input logic rdy,
                   input logic [2:0] c, input logic p, input logic b, input logic d);
    vec_t e;
    e.rst = rst; e.st = st; e.md = md; e.rdy = rdy;
    e.cntl = c; e.page1 = p; e.busy = b; e.done = d;
    tbl.push_back(e);
  endtask

  logic [2:0] ax_cntl [6];
  logic       ax_inc  [6];
  logic       ax_done [6];

  initial begin
    RST = 1'b1; START = 1'b0; MODE = 3'd0; READY = 1'b0; CARRY = 1'b0;
    repeat (2) @(negedge clk);

    // reset state, then ABS back-to-back into STK
    v(1,0,0,0, 3'b000,0,0,0);
    v(0,1,2,1, 3'b000,0,0,0);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,1,4,1, 3'b010,0,1,1);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,0,0,1, 3'b100,1,1,1);
    v(0,0,0,1, 3'b000,0,0,0);
    // ZP with READY low for 3 cycles on the page step
    v(0,1,1,1, 3'b000,0,0,0);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,0,0,0, 3'b100,0,1,0);
    v(0,0,0,0, 3'b100,0,1,0);
    v(0,0,0,0, 3'b100,0,1,0);
    v(0,0,0,1, 3'b100,0,1,1);
    v(0,0,0,1, 3'b000,0,0,0);
    // reserved mode 7
    v(0,1,7,1, 3'b000,0,0,0);
    v(0,0,0,1, 3'b001,0,1,1);
    v(0,0,0,1, 3'b000,0,0,0);
    // START while busy is ignored
    v(0,1,2,1, 3'b000,0,0,0);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,1,0,1, 3'b001,0,1,0);
    v(0,0,0,1, 3'b010,0,1,1);
    v(0,0,0,1, 3'b000,0,0,0);
    // reset during a stalled IND step 2, then ABS
    v(0,1,5,1, 3'b000,0,0,0);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,0,0,0, 3'b010,0,1,0);
    v(1,0,0,0, 3'b010,0,1,0);
    v(0,0,0,0, 3'b000,0,0,0);
    v(0,1,2,1, 3'b000,0,0,0);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,0,0,1, 3'b001,0,1,0);
    v(0,0,0,1, 3'b010,0,1,1);
    v(0,0,0,1, 3'b000,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].md, tbl[i].rdy, 1'b0);
      chk($sformatf("vec%0d_cntl", i), {5'd0, s_cntl}, {5'd0, tbl[i].cntl});
      chk($sformatf("vec%0d_busy", i), {7'd0, s_busy}, {7'd0, tbl[i].busy});
      chk($sformatf("vec%0d_done", i), {7'd0, s_done}, {7'd0, tbl[i].done});
      chk($sformatf("vec%0d_inc", i), {7'd0, s_inc}, 8'd0);
      if (tbl[i].cntl[2]) chk($sformatf("vec%0d_page1", i), {7'd0, s_page1}, {7'd0, tbl[i].page1});
    end

    // ABSX with CARRY in the third step
    ax_cntl = '{3'b000, 3'b001, 3'b001, 3'b010, FIXEN ? 3'b010 : 3'b000, 3'b000};
    ax_inc  = '{1'b0, 1'b0, 1'b0, 1'b0, FIXEN, 1'b0};
    ax_done = '{1'b0, 1'b0, 1'b0, !FIXEN, FIXEN, 1'b0};
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, (c == 0), 3, 1'b1, (c == 3));
      chk($sformatf("absx%0d_cntl", c), {5'd0, s_cntl}, {5'd0, ax_cntl[c]});
      chk($sformatf("absx%0d_inc", c), {7'd0, s_inc}, {7'd0, ax_inc[c]});
      chk($sformatf("absx%0d_done", c), {7'd0, s_done}, {7'd0, ax_done[c]});
    end

    // randomized traffic against the step-list model
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(99) == 0), 1'($urandom_range(1)), int'($urandom_range(7)),
          ($urandom_range(3) != 0), 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
